imm_gen_pipe: RTL and testbench

- Parametrised, pipelined immediate generator for the decode stage.
- Extracts and sign-extends the RV32I/RV64I immediate formats (I, S, B, J, U) from a full 32-bit instruction to XLEN bits.
- Registers the result behind a valid/ready elastic stage with a 2-entry skid buffer, with flush support, so it can sit on the D->E pipeline boundary.
- Carries a sideband tag (PC or ROB index) alongside each immediate.

---
 rtl/imm_gen_pipe.sv | 124 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator behind a valid/ready stage with a 2-entry skid buffer.
// Define IMM_GEN_CSR_ZIMM_EN to decode source 101 as the zero-extended CSR immediate.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    typedef enum logic [2:0] {
        SRC_I = 3'b000,
        SRC_S = 3'b001,
        SRC_B = 3'b010,
        SRC_J = 3'b011,
        SRC_U = 3'b100,
        SRC_Z = 3'b101
    } imm_src_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             illegal;
        logic             valid;
    } entry_t;

    entry_t      out_q, out_d;
    entry_t      skid_q, skid_d;
    entry_t      in_entry;
    logic        in_ready_q, in_ready_d;
    logic        accept;
    logic [31:0] imm32;
    logic        illegal_in;

    // The major opcode never contributes to any immediate.
    logic unused_opcode;
    assign unused_opcode = ^in_instr[6:0];

    // Every format fits in 32 bits; the XLEN sign extension is a single cast afterwards.
    always_comb begin
        // NOTE: defaults first on every path so no latch is inferred for imm32/illegal_in.
        imm32      = '0;
        illegal_in = 1'b0;
        case (in_imm_src)
            SRC_I: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            SRC_S: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            SRC_B: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
            SRC_J: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
            SRC_U: imm32 = {in_instr[31:12], 12'b0};
`ifdef IMM_GEN_CSR_ZIMM_EN
            SRC_Z: imm32 = {27'b0, in_instr[19:15]};
`else
            SRC_Z: illegal_in = 1'b1;
`endif
            default: illegal_in = 1'b1;
        endcase
    end

    always_comb begin
        in_entry.imm     = XLEN'($signed(imm32));
        in_entry.tag     = in_tag;
        in_entry.illegal = illegal_in;
        in_entry.valid   = 1'b1;
    end

    assign accept = in_valid && in_ready_q;

    always_comb begin
        out_d = out_q;
        skid_d = skid_q;
        if (flush) begin
            out_d.valid  = 1'b0;
            skid_d.valid = 1'b0;
        end else if (!out_q.valid || out_ready) begin
            if (skid_q.valid) begin
                // Skid entry is older than anything arriving now, so it goes out first.
                out_d = skid_q;
                if (accept) skid_d = in_entry;
                else        skid_d.valid = 1'b0;
            end else if (accept) begin
                out_d = in_entry;
            end else begin
                out_d.valid = 1'b0;
            end
        end else if (accept) begin
            skid_d = in_entry;
        end
        in_ready_d = !skid_d.valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: data fields are reset too, so the outputs read all-zero during reset.
            out_q      <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            out_q      <= out_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_q.valid;
    assign out_imm     = out_q.imm;
    assign out_tag     = out_q.tag;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 32-bit and a 64-bit instance share the same stimulus.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [2:0]  in_imm_src;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_imm, out_tag;

    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [7:0]  out_tag64;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_tag(out_tag), .out_illegal(out_illegal)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
        .in_imm_src(in_imm_src), .in_tag(in_tag[7:0]),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_tag(out_tag64), .out_illegal(out_illegal64)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vec(input string name, input logic [31:0] instr, input logic [2:0] src,
                       input logic [31:0] tag, input logic [31:0] e32, input logic [63:0] e64,
                       input logic e_ill);
        in_valid   = 1'b1;
        in_instr   = instr;
        in_imm_src = src;
        in_tag     = tag;
        tick();
        check({name, ".valid"}, 64'(out_valid), 64'd1);
        check({name, ".imm"}, 64'(out_imm), 64'(e32));
        check({name, ".tag"}, 64'(out_tag), 64'(tag));
        check({name, ".illegal"}, 64'(out_illegal), 64'(e_ill));
        check({name, ".imm64"}, out_imm64, e64);
        check({name, ".illegal64"}, 64'(out_illegal64), 64'(e_ill));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
        in_imm_src = '0; in_tag = '0; out_ready = 1'b1;
        tick();
        tick();
        check("rst.valid", 64'(out_valid), 64'd0);
        check("rst.imm", 64'(out_imm), 64'd0);
        check("rst.tag", 64'(out_tag), 64'd0);
        check("rst.illegal", 64'(out_illegal), 64'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst.in_ready", 64'(in_ready), 64'd1);
        check("post_rst.valid", 64'(out_valid), 64'd0);

        // Back-to-back formats, no backpressure: each result appears one edge later.
        vec("i_neg",  32'hFFF00093, 3'b000, 32'h10, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        vec("i_pos",  32'h7FF00093, 3'b000, 32'h11, 32'h000007FF, 64'h00000000000007FF, 1'b0);
        vec("s_pos",  32'h02A00123, 3'b001, 32'h12, 32'h00000022, 64'h0000000000000022, 1'b0);
        vec("s_neg",  32'h80000023, 3'b001, 32'h13, 32'hFFFFF800, 64'hFFFFFFFFFFFFF800, 1'b0);
        vec("b_neg",  32'hFE000EE3, 3'b010, 32'h14, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        vec("j_pos",  32'h001000EF, 3'b011, 32'h15, 32'h00000800, 64'h0000000000000800, 1'b0);
        vec("u_pos",  32'h123452B7, 3'b100, 32'h16, 32'h12345000, 64'h0000000012345000, 1'b0);
        vec("u_neg",  32'h80000537, 3'b100, 32'h17, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0);
        vec("ill7",   32'hFFFFFFFF, 3'b111, 32'h18, 32'h00000000, 64'h0000000000000000, 1'b1);
        vec("ill6",   32'hFFFFFFFF, 3'b110, 32'h19, 32'h00000000, 64'h0000000000000000, 1'b1);
`ifdef IMM_GEN_CSR_ZIMM_EN
        vec("zimm",   32'h000F8073, 3'b101, 32'h1A, 32'h0000001F, 64'h000000000000001F, 1'b0);
`else
        vec("zimm",   32'h000F8073, 3'b101, 32'h1A, 32'h00000000, 64'h0000000000000000, 1'b1);
`endif
        in_valid = 1'b0;
        tick();
        check("drain.valid", 64'(out_valid), 64'd0);

        // Backpressure: tags 1..4 with the consumer stalled for three edges.
        out_ready = 1'b0;
        in_valid = 1'b1; in_imm_src = 3'b000;
        in_instr = 32'h00100093; in_tag = 32'd1;
        tick();
        check("bp1.tag", 64'(out_tag), 64'd1);
        check("bp1.in_ready", 64'(in_ready), 64'd1);
        in_instr = 32'h00200093; in_tag = 32'd2;
        tick();
        check("bp2.tag", 64'(out_tag), 64'd1);
        check("bp2.in_ready", 64'(in_ready), 64'd0);
        in_instr = 32'h00300093; in_tag = 32'd3;
        tick();
        check("bp3.valid", 64'(out_valid), 64'd1);
        check("bp3.tag", 64'(out_tag), 64'd1);
        check("bp3.imm", 64'(out_imm), 64'd1);
        check("bp3.in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        check("rel1.tag", 64'(out_tag), 64'd2);
        check("rel1.imm", 64'(out_imm), 64'd2);
        check("rel1.in_ready", 64'(in_ready), 64'd1);
        tick();
        check("rel2.tag", 64'(out_tag), 64'd3);
        check("rel2.valid", 64'(out_valid), 64'd1);
        in_instr = 32'h00400093; in_tag = 32'd4;
        tick();
        check("rel3.tag", 64'(out_tag), 64'd4);
        check("rel3.imm", 64'(out_imm), 64'd4);
        in_valid = 1'b0;
        tick();
        check("rel4.valid", 64'(out_valid), 64'd0);

        // Flush while stalled with the skid full and a new input offered.
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h02100093; in_tag = 32'h21;
        tick();
        in_instr = 32'h02200093; in_tag = 32'h22;
        tick();
        check("fl_pre.in_ready", 64'(in_ready), 64'd0);
        flush = 1'b1;
        in_instr = 32'h02300093; in_tag = 32'h23;
        tick();
        check("fl.valid", 64'(out_valid), 64'd0);
        check("fl.in_ready", 64'(in_ready), 64'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("fl_after1.valid", 64'(out_valid), 64'd0);
        tick();
        check("fl_after2.valid", 64'(out_valid), 64'd0);
        vec("fl_next", 32'h02400093, 3'b000, 32'h24, 32'h00000024, 64'h0000000000000024, 1'b0);

        // Asynchronous reset in the middle of a stall.
        out_ready = 1'b0;
        in_instr = 32'hFFF00093; in_tag = 32'h31;
        tick();
        in_instr = 32'h03200093; in_tag = 32'h32;
        tick();
        check("mid_pre.valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst.valid", 64'(out_valid), 64'd0);
        check("mid_rst.imm", 64'(out_imm), 64'd0);
        check("mid_rst.tag", 64'(out_tag), 64'd0);
        check("mid_rst.illegal", 64'(out_illegal), 64'd0);
        check("mid_rst.imm64", out_imm64, 64'd0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        check("mid_post.in_ready", 64'(in_ready), 64'd1);
        check("mid_post.valid", 64'(out_valid), 64'd0);
        vec("mid_next", 32'h03300093, 3'b000, 32'h33, 32'h00000033, 64'h0000000000000033, 1'b0);
        in_valid = 1'b0;
        tick();
        check("end.valid", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
